// File: rtl/traffic_phase_controller.sv
// Highway/country-road four-phase traffic controller driven by a tick time base.
// Optional flash mode is compiled in when TRAFFIC_FLASH_EN is defined.
module traffic_phase_controller #(
  parameter int CNT_W    = 8,
  parameter int HG_MIN   = 20,
  parameter int YEL_TIME = 4,
  parameter int SG_MAX   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             car,
`ifdef TRAFFIC_FLASH_EN
  input  logic             flash,
`endif
  output logic [1:0]       state,
  output logic [CNT_W-1:0] phase_cnt,
  output logic             country_red,
  output logic             country_yellow,
  output logic             country_green,
  output logic             highway_red,
  output logic             highway_yellow,
  output logic             highway_green
);

  typedef enum logic [1:0] {
    HG = 2'b00,
    HY = 2'b01,
    SG = 2'b11,
    SY = 2'b10
  } phase_e;

  localparam logic [CNT_W-1:0] HG_LAST  = CNT_W'(HG_MIN - 1);
  localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YEL_TIME - 1);
  localparam logic [CNT_W-1:0] SG_LAST  = CNT_W'(SG_MAX - 1);

  // Lamp vector order: {hwy_red, hwy_yellow, hwy_green, cty_red, cty_yellow, cty_green}.
  function automatic logic [5:0] lamp_map(input phase_e p);
    case (p)
      HG:      lamp_map = 6'b001_100;
      HY:      lamp_map = 6'b010_100;
      SG:      lamp_map = 6'b100_001;
      default: lamp_map = 6'b100_010;
    endcase
  endfunction

  phase_e           cur, nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [5:0]       lamps;

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    nxt     = cur;
    cnt_nxt = phase_cnt;
    if (tick) begin
      case (cur)
        HG: begin
          if (phase_cnt >= HG_LAST && car) begin
            nxt     = HY;
            cnt_nxt = '0;
          end else if (phase_cnt < HG_LAST) begin
            cnt_nxt = phase_cnt + CNT_W'(1);
          end
        end
        HY: begin
          if (phase_cnt == YEL_LAST) begin
            nxt     = SG;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = phase_cnt + CNT_W'(1);
          end
        end
        SG: begin
          if (!car || phase_cnt == SG_LAST) begin
            nxt     = SY;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = phase_cnt + CNT_W'(1);
          end
        end
        default: begin
          if (phase_cnt == YEL_LAST) begin
            nxt     = HG;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = phase_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

`ifdef TRAFFIC_FLASH_EN
  logic flash_q;
  logic blink;
  logic blink_nxt;

  // Blink starts lit on the first flash cycle, then toggles on each tick.
  always_comb begin
    blink_nxt = blink;
    if (!flash_q)  blink_nxt = 1'b1;
    else if (tick) blink_nxt = ~blink;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= HG;
      phase_cnt <= '0;
      lamps     <= lamp_map(HG);
`ifdef TRAFFIC_FLASH_EN
      flash_q   <= 1'b0;
      blink     <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values together.
      cur       <= nxt;
      phase_cnt <= cnt_nxt;
      lamps     <= lamp_map(nxt);
`ifdef TRAFFIC_FLASH_EN
      flash_q   <= flash;
      blink     <= flash ? blink_nxt : 1'b0;
      if (flash) begin
        cur       <= HG;
        phase_cnt <= '0;
        lamps     <= {1'b0, blink_nxt, 1'b0, blink_nxt, 2'b00};
      end
`endif
    end
  end

  assign state = cur;
  assign {highway_red, highway_yellow, highway_green,
          country_red, country_yellow, country_green} = lamps;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Self-checking bench for traffic_phase_controller: phase-level model compared every cycle,
// plus directed literal checks of the timing points.
module tb_traffic_phase_controller;

  localparam int CNT_W    = 4;
  localparam int HG_MIN   = 3;
  localparam int YEL_TIME = 2;
  localparam int SG_MAX   = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             tick = 1'b0;
  logic             car = 1'b0;
`ifdef TRAFFIC_FLASH_EN
  logic             flash = 1'b0;
`endif
  logic [1:0]       state;
  logic [CNT_W-1:0] phase_cnt;
  logic             country_red, country_yellow, country_green;
  logic             highway_red, highway_yellow, highway_green;

  int errors = 0;
  int checks = 0;

  traffic_phase_controller #(
    .CNT_W(CNT_W), .HG_MIN(HG_MIN), .YEL_TIME(YEL_TIME), .SG_MAX(SG_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .car(car),
`ifdef TRAFFIC_FLASH_EN
    .flash(flash),
`endif
    .state(state), .phase_cnt(phase_cnt),
    .country_red(country_red), .country_yellow(country_yellow), .country_green(country_green),
    .highway_red(highway_red), .highway_yellow(highway_yellow), .highway_green(highway_green)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Phase-level model: phase index 0..3 walks HG, HY, SG, SY in order.
  logic [1:0] code_of [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  logic [5:0] lamp_of [4] = '{6'b001100, 6'b010100, 6'b100001, 6'b100010};
  int   m_phase = 0;
  int   m_cnt   = 0;
  logic m_flash = 1'b0;
  logic m_blink = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_cnt   <= 0;
      m_flash <= 1'b0;
      m_blink <= 1'b0;
    end else begin
`ifdef TRAFFIC_FLASH_EN
      m_flash <= flash;
      if (flash) begin
        m_phase <= 0;
        m_cnt   <= 0;
        m_blink <= !m_flash ? 1'b1 : (tick ? !m_blink : m_blink);
      end else
`endif
      if (tick) begin
        int limit;
        logic leave;
        case (m_phase)
          0:       begin limit = HG_MIN;   leave = (m_cnt >= HG_MIN - 1) && car; end
          2:       begin limit = SG_MAX;   leave = !car || (m_cnt == SG_MAX - 1); end
          default: begin limit = YEL_TIME; leave = (m_cnt == YEL_TIME - 1); end
        endcase
        if (leave) begin
          m_phase <= (m_phase + 1) % 4;
          m_cnt   <= 0;
        end else begin
          m_cnt <= (m_cnt + 1 > limit - 1) ? limit - 1 : m_cnt + 1;
        end
      end
    end
  end

  function automatic logic [15:0] model_vec();
    logic [5:0] lmp;
    lmp = m_flash ? {1'b0, m_blink, 1'b0, m_blink, 2'b00} : lamp_of[m_phase];
    return {4'h0, code_of[m_phase], CNT_W'(m_cnt), lmp};
  endfunction

  function automatic logic [15:0] dut_vec();
    return {4'h0, state, phase_cnt, highway_red, highway_yellow, highway_green,
            country_red, country_yellow, country_green};
  endfunction

  always @(negedge clk) check("model", dut_vec(), model_vec());

  task automatic cyc(input logic t, input logic c);
    tick = t;
    car  = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick  = 1'b0;
    car   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Literal expectations use {state, phase_cnt, lamps}.
  function automatic logic [15:0] lit(input logic [1:0] s, input int c, input logic [5:0] l);
    return {4'h0, s, CNT_W'(c), l};
  endfunction

  initial begin
    do_reset();
    check("reset_state", dut_vec(), lit(2'b00, 0, 6'b001100));

    // Full cycle with car present and a tick every cycle.
    for (int t = 1; t <= 11; t++) begin
      cyc(1'b1, 1'b1);
      case (t)
        3:  check("full_t3_HY",  dut_vec(), lit(2'b01, 0, 6'b010100));
        5:  check("full_t5_SG",  dut_vec(), lit(2'b11, 0, 6'b100001));
        8:  check("full_t8_SG3", dut_vec(), lit(2'b11, 3, 6'b100001));
        9:  check("full_t9_SY",  dut_vec(), lit(2'b10, 0, 6'b100010));
        11: check("full_t11_HG", dut_vec(), lit(2'b00, 0, 6'b001100));
        default: ;
      endcase
    end

    // No car: HG saturates at HG_MIN-1, then car leaves on the next tick.
    do_reset();
    repeat (20) cyc(1'b1, 1'b0);
    check("nocar_sat", dut_vec(), lit(2'b00, 2, 6'b001100));
    cyc(1'b1, 1'b1);
    check("nocar_then_car", dut_vec(), lit(2'b01, 0, 6'b010100));

    // Early SG exit when the car leaves.
    do_reset();
    repeat (6) cyc(1'b1, 1'b1);
    check("early_sg1", dut_vec(), lit(2'b11, 1, 6'b100001));
    cyc(1'b1, 1'b0);
    check("early_sy", dut_vec(), lit(2'b10, 0, 6'b100010));
    repeat (2) cyc(1'b1, 1'b0);
    check("early_hg", dut_vec(), lit(2'b00, 0, 6'b001100));

    // Tick gating: no change without tick, even with car toggling.
    do_reset();
    repeat (6) cyc(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b0, i[0]);
    check("gate_hold", dut_vec(), lit(2'b11, 1, 6'b100001));

    // Asynchronous reset mid-cycle.
    #2 rst_n = 1'b0;
    #1 check("async_rst", dut_vec(), lit(2'b00, 0, 6'b001100));
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 1'b0);
    check("post_rst_tick1", dut_vec(), lit(2'b00, 1, 6'b001100));

`ifdef TRAFFIC_FLASH_EN
    do_reset();
    repeat (6) cyc(1'b1, 1'b1);
    flash = 1'b1;
    cyc(1'b1, 1'b1);
    check("flash_on", dut_vec(), lit(2'b00, 0, 6'b010100));
    cyc(1'b1, 1'b1);
    check("flash_blink0", dut_vec(), lit(2'b00, 0, 6'b000000));
    cyc(1'b0, 1'b1);
    check("flash_hold", dut_vec(), lit(2'b00, 0, 6'b000000));
    cyc(1'b1, 1'b1);
    check("flash_blink1", dut_vec(), lit(2'b00, 0, 6'b010100));
    flash = 1'b0;
    cyc(1'b0, 1'b1);
    check("flash_off", dut_vec(), lit(2'b00, 0, 6'b001100));
    repeat (3) cyc(1'b1, 1'b1);
    check("flash_to_hy", dut_vec(), lit(2'b01, 0, 6'b010100));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
